// File: rtl/z_octal_ram_init_seq_if.sv
// z_octal_ram_init_seq_if: config-table, command-engine and status signals of the PSRAM init sequencer.
interface z_octal_ram_init_seq_if;
    logic       iStart;
    logic [7:0] oCfgNo;
    logic [7:0] iRegAddr;
    logic [7:0] iRegData;
    logic       oCmdValid;
    logic       iCmdReady;
    logic       oCmdRd;
    logic [7:0] oCmdAddr;
    logic [7:0] oCmdData;
    logic       iCmdDone;
    logic [7:0] iRdData;
    logic       oBusy;
    logic       oDone;
    logic       oErr;
    logic [1:0] oErrCode;
    logic [7:0] oErrIdx;

    modport master (
        input  iStart, iRegAddr, iRegData, iCmdReady, iCmdDone, iRdData,
        output oCfgNo, oCmdValid, oCmdRd, oCmdAddr, oCmdData, oBusy, oDone, oErr, oErrCode, oErrIdx
    );
    modport slave (
        output iStart, iRegAddr, iRegData, iCmdReady, iCmdDone, iRdData,
        input  oCfgNo, oCmdValid, oCmdRd, oCmdAddr, oCmdData, oBusy, oDone, oErr, oErrCode, oErrIdx
    );
endinterface

// File: rtl/z_octal_ram_init_seq.sv
// z_octal_ram_init_seq: walks the mode-register table after power-up, issuing MRW then MRR commands and checking read-backs.
module z_octal_ram_init_seq #(
    parameter int         PWR_WAIT_CYC = 20000,
    parameter int         NUM_WR       = 4,
    parameter int         NUM_TOTAL    = 10,
    parameter int         TIMEOUT_CYC  = 1024,
    parameter logic [7:0] MR0_MASK     = 8'h3F,
    parameter logic [7:0] MR4_MASK     = 8'hE7,
    parameter logic [7:0] MR8_MASK     = 8'h0F
) (
    input  logic                   iClk,
    input  logic                   iRst_N,
    z_octal_ram_init_seq_if.master bus
);
    typedef enum logic [2:0] {PWR_WAIT, LOAD, REQ, WAIT_DONE, CHECK, DONE, FAIL} state_t;
    localparam int CW = $clog2((PWR_WAIT_CYC > TIMEOUT_CYC ? PWR_WAIT_CYC : TIMEOUT_CYC) + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cfg_q, cfg_d, addr_q, addr_d, data_q, data_d, rdat_q, rdat_d, eidx_q, eidx_d;
    logic [7:0]    wr0_q, wr0_d, wr1_q, wr1_d, wr3_q, wr3_d;
    logic [1:0]    ecode_q, ecode_d;
    logic          rd_q, rd_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          mism;

    always_ff @(posedge iClk) begin
        if (!iRst_N) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            cfg_q   <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            rdat_q  <= 8'h00;
            eidx_q  <= 8'h00;
            wr0_q   <= 8'h00;
            wr1_q   <= 8'h00;
            wr3_q   <= 8'h00;
            ecode_q <= 2'b00;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdat_q  <= rdat_d;
            eidx_q  <= eidx_d;
            wr0_q   <= wr0_d;
            wr1_q   <= wr1_d;
            wr3_q   <= wr3_d;
            ecode_q <= ecode_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Only MR0, MR4 and MR8 read-backs are compared, each against its own written copy.
    always_comb begin
        mism = cfg_q == 8'd4 ? ((rdat_q ^ wr0_q) & MR0_MASK) != 8'h00
             : cfg_q == 8'd8 ? ((rdat_q ^ wr1_q) & MR4_MASK) != 8'h00
             : cfg_q == 8'd9 ? ((rdat_q ^ wr3_q) & MR8_MASK) != 8'h00 : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdat_d  = rdat_q;
        eidx_d  = eidx_q;
        wr0_d   = wr0_q;
        wr1_d   = wr1_q;
        wr3_d   = wr3_q;
        ecode_d = ecode_q;
        rd_d    = rd_q;
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == CW'(PWR_WAIT_CYC - 1)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CW'(1);
            end
            LOAD: begin
                addr_d  = bus.iRegAddr;
                rd_d    = cfg_q >= 8'(NUM_WR);
                data_d  = rd_d ? 8'h00 : bus.iRegData;
                wr0_d   = (!rd_d && cfg_q == 8'd0) ? bus.iRegData : wr0_q;
                wr1_d   = (!rd_d && cfg_q == 8'd1) ? bus.iRegData : wr1_q;
                wr3_d   = (!rd_d && cfg_q == 8'd3) ? bus.iRegData : wr3_q;
                state_d = REQ;
            end
            REQ: begin
                if (bus.iCmdReady) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end
            end
            WAIT_DONE: begin
                if (bus.iCmdDone) begin
                    state_d = CHECK;
                    rdat_d  = rd_q ? bus.iRdData : rdat_q;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = FAIL;
                    ecode_d = 2'b01;
                    eidx_d  = cfg_q;
                end else cnt_d = cnt_q + CW'(1);
            end
            CHECK: begin
                if (mism) begin
                    state_d = FAIL;
                    ecode_d = 2'b10;
                    eidx_d  = cfg_q;
                end else if (cfg_q == 8'(NUM_TOTAL - 1)) state_d = DONE;
                else begin
                    cfg_d   = cfg_q + 8'd1;
                    state_d = LOAD;
                end
            end
            default: begin
                if (bus.iStart) begin
                    state_d = LOAD;
                    cfg_d   = 8'h00;
                    ecode_d = 2'b00;
                    eidx_d  = 8'h00;
                end
            end
        endcase
    end

    always_comb begin
        valid_d = state_d == REQ;
        busy_d  = state_d != DONE && state_d != FAIL;
        done_d  = state_d == DONE;
        err_d   = state_d == FAIL;
    end

    assign bus.oCfgNo    = cfg_q;
    assign bus.oCmdValid = valid_q;
    assign bus.oCmdRd    = rd_q;
    assign bus.oCmdAddr  = addr_q;
    assign bus.oCmdData  = data_q;
    assign bus.oBusy     = busy_q;
    assign bus.oDone     = done_q;
    assign bus.oErr      = err_q;
    assign bus.oErrCode  = ecode_q;
    assign bus.oErrIdx   = eidx_q;
endmodule
